cipher_cfg_loader: RTL and testbench

Serial configuration master for the dual XOR stream cipher's key/seed chain. It accepts an M-bit key word over a valid/ready handshake and shifts it MSB-first into the cipher's configuration shift chain via `cfg_en`/`cfg_d`. It can then optionally re-shift the same word while checking the bits returned on the chain output, and report pass/fail. It sits between the host-side key source and the cipher's `cfg_en`/`cfg_i`/`cfg_o` pins, and holds `cfg_busy` so the cipher's tx/rx paths can be gated during loading.

---
 rtl/cipher_cfg_loader_if.sv | 24 ++
 rtl/cipher_cfg_loader.sv | 151 +++++++++++++++
 tb/tb_cipher_cfg_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_cfg_loader_if.sv
// Key handshake bundle between the host-side key source and the configuration
// loader. The key source is the master and the loader is the slave.
interface cipher_cfg_loader_if #(
  parameter int unsigned M = 32
) ();
  logic         key_valid;
  logic         key_ready;
  logic [M-1:0] key_data;
  logic         verify;

  modport master (
    output key_valid,
    output key_data,
    output verify,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_data,
    input  verify,
    output key_ready
  );
endinterface

// File: rtl/cipher_cfg_loader.sv
// Serial configuration master for the cipher key/seed chain. It accepts one
// M-bit key word, shifts it MSB-first into the chain, and can then re-shift
// the same word while comparing the bits returned on the chain output.
module cipher_cfg_loader #(
  parameter int unsigned M = 32
) (
  input  logic               clk,
  input  logic               rst,
  cipher_cfg_loader_if.slave key_if,
  output logic               cfg_en_o,
  output logic               cfg_d_o,
  input  logic               cfg_q_i,
  output logic               cfg_busy_o,
  output logic               done_o,
  output logic               ok_o
);

  localparam int unsigned      CNT_W    = (M > 1) ? $clog2(M) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [M-1:0]     key_q, key_d;
  logic             verify_q, verify_d;
  logic             mismatch_q, mismatch_d;
  logic             cfg_en_q, cfg_en_d;
  logic             cfg_d_q, cfg_d_d;
  logic             cfg_busy_q, cfg_busy_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;

  logic             accept;
  logic             last_bit;
  logic             bit_err;
  logic             shifting_next;

  assign accept   = key_if.key_valid && (state_q == ST_IDLE);
  assign last_bit = (cnt_q == CNT_LAST);
  // key_q[M-1] is the bit being driven this cycle, so it is also the bit
  // expected back from the chain while re-writing during CHECK.
  assign bit_err  = (state_q == ST_CHECK) && (cfg_q_i != key_q[M-1]);

  assign key_if.key_ready = (state_q == ST_IDLE);

  // State register; reset wins over a simultaneous key offer.
  always_ff @(posedge clk) begin
    // NOTE: every register is assigned with <= so all flops update from the
    // pre-edge values; a blocking = here would chain them within one edge.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> LOAD -> (CHECK) -> DONE -> IDLE.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d
    // unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      ST_LOAD:  if (last_bit) state_d = verify_q ? ST_CHECK : ST_DONE;
      ST_CHECK: if (last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are derived from the next state
  // so the registered pins line up with the state they belong to.
  always_comb begin
    shifting_next = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    cfg_en_d      = shifting_next;
    cfg_busy_d    = shifting_next;
    done_d        = (state_d == ST_DONE);
    cfg_d_d       = 1'b0;
    ok_d          = ok_q;
    cnt_d         = cnt_q;
    key_d         = key_q;
    verify_d      = verify_q;
    mismatch_d    = mismatch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          key_d      = key_if.key_data;
          verify_d   = key_if.verify;
          mismatch_d = 1'b0;
          ok_d       = 1'b0;
          cnt_d      = '0;
          cfg_d_d    = key_if.key_data[M-1];
        end
      end
      ST_LOAD, ST_CHECK: begin
        // Rotate left: after M shifts the word is back in place for CHECK.
        key_d      = {key_q[M-2:0], key_q[M-1]};
        cnt_d      = last_bit ? '0 : cnt_q + CNT_W'(1);
        mismatch_d = mismatch_q | bit_err;
        if (shifting_next) cfg_d_d = key_q[M-2];
        // The final CHECK compare lands on the same edge that enters DONE.
        if (state_d == ST_DONE) ok_d = verify_q ? !(mismatch_q | bit_err) : 1'b1;
      end
      ST_DONE: ;
      default: ;
    endcase
  end

  // Control, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      verify_q   <= 1'b0;
      mismatch_q <= 1'b0;
      cfg_en_q   <= 1'b0;
      cfg_d_q    <= 1'b0;
      cfg_busy_q <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      verify_q   <= verify_d;
      mismatch_q <= mismatch_d;
      cfg_en_q   <= cfg_en_d;
      cfg_d_q    <= cfg_d_d;
      cfg_busy_q <= cfg_busy_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
    end
  end

  // Key shift register.
  always_ff @(posedge clk) begin
    // NOTE: the key word is pure datapath, loaded on every accept before it
    // is used, so it carries no reset.
    key_q <= key_d;
  end

  assign cfg_en_o   = cfg_en_q;
  assign cfg_d_o    = cfg_d_q;
  assign cfg_busy_o = cfg_busy_q;
  assign done_o     = done_q;
  assign ok_o       = ok_q;

endmodule

// File: tb/tb_cipher_cfg_loader.sv
// Bench for cipher_cfg_loader: a behavioural chain model on the cfg pins,
// directed scenarios and a randomized run compared against expectations
// computed from the key word, the verify flag and the readback corruption.
module tb_cipher_cfg_loader;
  localparam int M = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cipher_cfg_loader_if #(.M(M)) kif ();

  logic cfg_en, cfg_d, cfg_q, cfg_busy, done, ok;

  cipher_cfg_loader #(.M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_if     (kif),
    .cfg_en_o   (cfg_en),
    .cfg_d_o    (cfg_d),
    .cfg_q_i    (cfg_q),
    .cfg_busy_o (cfg_busy),
    .done_o     (done),
    .ok_o       (ok)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Chain model: M-bit shift register, cfg_i enters at bit 0, cfg_o is MSB.
  logic [M-1:0] chain;
  logic [M-1:0] preload_val;
  logic         preload_req = 1'b0;
  logic         flip_bit7   = 1'b0;
  int           shift_cnt   = 0;

  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (cfg_en) chain <= {chain[M-2:0], cfg_d};
    if (cfg_en) shift_cnt <= shift_cnt + 1;
    else        shift_cnt <= 0;
  end

  // During CHECK cycle i the MSB holds key bit M-1-i; bit 7 shows up at i=M-8.
  assign cfg_q = chain[M-1] ^ (flip_bit7 && (shift_cnt == 2*M - 8));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [M-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
  endtask

  // Offers one key and records what the pins do, offset k = sample after edge A+k.
  task automatic run_op(input logic [M-1:0] key, input logic ver,
                        output bit acc_ok, output int en_first, output int en_cnt,
                        output logic [2*M-1:0] dseq, output int done_off,
                        output logic ok_at_done, output logic ok_at_acc,
                        output logic [M-1:0] chain_at_done);
    acc_ok = 1'b0; en_first = -1; en_cnt = 0; dseq = '0; done_off = -1;
    ok_at_done = 1'bx; ok_at_acc = 1'bx; chain_at_done = 'x;
    kif.key_valid = 1'b1; kif.key_data = key; kif.verify = ver;
    for (int w = 0; w < 4*M && !kif.key_ready; w++) begin @(posedge clk); #1; end
    if (!kif.key_ready) begin kif.key_valid = 1'b0; return; end
    @(posedge clk); #1;
    acc_ok = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_data  = $urandom();
    kif.verify    = 1'($urandom_range(0, 1));
    for (int k = 0; k < 3*M; k++) begin
      if (k == 0) ok_at_acc = ok;
      if (cfg_en) begin
        if (en_first < 0) en_first = k;
        if (en_cnt < 2*M) dseq[2*M-1-en_cnt] = cfg_d;
        en_cnt++;
      end
      if (done) begin
        done_off = k; ok_at_done = ok; chain_at_done = chain;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    kif.key_valid = 1'b1; kif.key_data = $urandom(); kif.verify = 1'b1;
    preload_val = '0; preload_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if ({kif.key_ready, cfg_en, cfg_d, cfg_busy, done, ok} !== 6'b100000) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got rdy/en/d/busy/done/ok=%b want 100000",
                 c, {kif.key_ready, cfg_en, cfg_d, cfg_busy, done, ok});
      end
      vectors++;
    end
    preload_req = 1'b0;
    kif.key_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    if ({cfg_en, cfg_busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_no_accept: got en/busy=%b want 00", {cfg_en, cfg_busy});
    end
    vectors++;
  endtask

  task automatic test_plain_load();
    bit acc; int ef, ec, doff; logic [2*M-1:0] ds; logic okd, oka; logic [M-1:0] ch;
    logic [M-1:0] key = 32'hA5C30F81;
    run_op(key, 1'b0, acc, ef, ec, ds, doff, okd, oka, ch);
    if (acc !== 1'b1) begin miscompares++; $display("FAIL plain_accept: got %0b want 1", acc); end
    vectors++;
    if (ef !== 0 || ec !== M) begin
      miscompares++; $display("FAIL plain_en_window: got first %0d count %0d want 0 %0d", ef, ec, M);
    end
    vectors++;
    if (ds[2*M-1:M] !== key) begin
      miscompares++; $display("FAIL plain_d_seq: got %h want %h", ds[2*M-1:M], key);
    end
    vectors++;
    if (doff !== M || okd !== 1'b1) begin
      miscompares++; $display("FAIL plain_done: got off %0d ok %b want %0d 1", doff, okd, M);
    end
    vectors++;
    if (ch !== key) begin miscompares++; $display("FAIL plain_chain: got %h want %h", ch, key); end
    vectors++;
  endtask

  task automatic test_verify_pass();
    bit acc; int ef, ec, doff; logic [2*M-1:0] ds; logic okd, oka; logic [M-1:0] ch;
    logic [M-1:0] key = 32'hDEADBEEF;
    preload(32'h12345678);
    run_op(key, 1'b1, acc, ef, ec, ds, doff, okd, oka, ch);
    if (ec !== 2*M || ds !== {key, key}) begin
      miscompares++; $display("FAIL vpass_shift: got count %0d seq %h want %0d %h", ec, ds, 2*M, {key, key});
    end
    vectors++;
    if (doff !== 2*M || okd !== 1'b1) begin
      miscompares++; $display("FAIL vpass_done: got off %0d ok %b want %0d 1", doff, okd, 2*M);
    end
    vectors++;
    if (oka !== 1'b0) begin miscompares++; $display("FAIL vpass_ok_clear: got %b want 0", oka); end
    vectors++;
    if (ch !== key) begin miscompares++; $display("FAIL vpass_chain: got %h want %h", ch, key); end
    vectors++;
  endtask

  task automatic test_verify_fail();
    bit acc; int ef, ec, doff; logic [2*M-1:0] ds; logic okd, oka; logic [M-1:0] ch;
    int bad;
    logic [M-1:0] key = 32'hDEADBEEF;
    preload(32'h12345678);
    flip_bit7 = 1'b1;
    run_op(key, 1'b1, acc, ef, ec, ds, doff, okd, oka, ch);
    flip_bit7 = 1'b0;
    if (doff !== 2*M || okd !== 1'b0) begin
      miscompares++; $display("FAIL vfail_done: got off %0d ok %b want %0d 0", doff, okd, 2*M);
    end
    vectors++;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ok !== 1'b0 || done !== 1'b0) bad++;
    end
    if (bad !== 0) begin miscompares++; $display("FAIL vfail_ok_hold: got %0d bad cycles want 0", bad); end
    vectors++;
    key = $urandom();
    run_op(key, 1'b0, acc, ef, ec, ds, doff, okd, oka, ch);
    if (oka !== 1'b0 || okd !== 1'b1) begin
      miscompares++; $display("FAIL vfail_next_op: got ok acc/done %b%b want 01", oka, okd);
    end
    vectors++;
  endtask

  task automatic test_back_to_back();
    int done1 = -1, acc2 = -1, done2 = -1;
    logic [M-1:0] ch1 = 'x, ch2 = 'x;
    kif.key_valid = 1'b1; kif.key_data = '0; kif.verify = 1'b0;
    for (int w = 0; w < 4*M && !kif.key_ready; w++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    kif.key_data = '1;
    for (int k = 0; k < 3*M; k++) begin
      if (done) begin done1 = k; ch1 = chain; end
      if (kif.key_ready) begin acc2 = k + 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    kif.key_valid = 1'b0;
    for (int k = 0; k < 3*M; k++) begin
      if (done) begin done2 = k; ch2 = chain; break; end
      @(posedge clk); #1;
    end
    if (done1 !== M || acc2 !== M + 2) begin
      miscompares++; $display("FAIL b2b_timing: got done %0d accept %0d want %0d %0d", done1, acc2, M, M + 2);
    end
    vectors++;
    if (ch1 !== '0) begin miscompares++; $display("FAIL b2b_first_key: got %h want 0", ch1); end
    vectors++;
    if (done2 !== M || ch2 !== '1) begin
      miscompares++; $display("FAIL b2b_second_key: got off %0d chain %h want %0d all-ones", done2, ch2, M);
    end
    vectors++;
  endtask

  task automatic test_mid_reset();
    bit acc; int ef, ec, doff; logic [2*M-1:0] ds; logic okd, oka; logic [M-1:0] ch;
    int bad;
    logic [M-1:0] key;
    kif.key_valid = 1'b1; kif.key_data = $urandom(); kif.verify = 1'b1;
    for (int w = 0; w < 4*M && !kif.key_ready; w++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    kif.key_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
    if (cfg_en !== 1'b1) begin miscompares++; $display("FAIL midrst_in_load: got en %b want 1", cfg_en); end
    vectors++;
    rst = 1'b1;
    @(posedge clk); #1;
    if ({kif.key_ready, cfg_en, cfg_busy, done, ok} !== 5'b10000) begin
      miscompares++;
      $display("FAIL midrst_state: got rdy/en/busy/done/ok=%b want 10000", {kif.key_ready, cfg_en, cfg_busy, done, ok});
    end
    vectors++;
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 2*M + 4; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || cfg_en !== 1'b0) bad++;
    end
    if (bad !== 0) begin miscompares++; $display("FAIL midrst_quiet: got %0d active cycles want 0", bad); end
    vectors++;
    key = $urandom();
    run_op(key, 1'b1, acc, ef, ec, ds, doff, okd, oka, ch);
    if (doff !== 2*M || okd !== 1'b1 || ch !== key) begin
      miscompares++;
      $display("FAIL midrst_reload: got off %0d ok %b chain %h want %0d 1 %h", doff, okd, ch, 2*M, key);
    end
    vectors++;
  endtask

  task automatic test_random();
    bit acc; int ef, ec, doff; logic [2*M-1:0] ds; logic okd, oka; logic [M-1:0] ch;
    logic [M-1:0] key; logic ver, flip, exp_ok; int exp_n;
    for (int n = 0; n < 10; n++) begin
      key  = $urandom();
      ver  = 1'($urandom_range(0, 1));
      flip = 1'($urandom_range(0, 1));
      exp_n  = ver ? 2*M : M;
      exp_ok = !(ver && flip);
      flip_bit7 = flip;
      run_op(key, ver, acc, ef, ec, ds, doff, okd, oka, ch);
      flip_bit7 = 1'b0;
      if (ef !== 0 || ec !== exp_n || doff !== exp_n) begin
        miscompares++;
        $display("FAIL rand%0d_timing: got first %0d count %0d done %0d want 0 %0d %0d", n, ef, ec, doff, exp_n, exp_n);
      end
      vectors++;
      if (ds !== (ver ? {key, key} : {key, {M{1'b0}}})) begin
        miscompares++; $display("FAIL rand%0d_d_seq: got %h key %h verify %b", n, ds, key, ver);
      end
      vectors++;
      if (okd !== exp_ok || oka !== 1'b0 || ch !== key) begin
        miscompares++;
        $display("FAIL rand%0d_result: got ok %b clr %b chain %h want %b 0 %h", n, okd, oka, ch, exp_ok, key);
      end
      vectors++;
    end
  endtask

  initial begin
    kif.key_valid = 1'b0; kif.key_data = '0; kif.verify = 1'b0;
    rst = 1'b1;
    test_reset();
    test_plain_load();
    test_verify_pass();
    test_verify_fail();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
